uart_rx_ctrl: RTL

Receive-side controller for the UART. It synchronises the serial input and detects the start bit, including glitch rejection. It then sequences oversampled mid-bit sampling of 8 data bits and the stop bit, and presents each completed byte through a valid/ready handshake with framing and overrun flags. It sits between the pin and the consumer, and is driven by the oversampling tick from the baud generator.

---
 rtl/uart_rx_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises the serial line, qualifies the start bit,
// samples 8 data bits plus stop at mid-bit and hands each byte out over valid/ready.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int CW         = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_data,
    input  logic       i_baud,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx,
    output logic       o_rx_valid,
    output logic [3:0] o_bit_count,
    output logic       o_start,
    output logic       o_busy,
    output logic       o_framing_err,
    output logic       o_overrun_err,
    output logic [1:0] o_state
);

    // Handshake: o_rx is offered while o_rx_valid=1; a byte is consumed on any
    // clock edge where o_rx_valid & i_rx_ready, and o_rx_valid drops after that
    // edge unless a freshly received byte is loaded on the same edge.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit_count;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx;
    logic          r_rx_valid;
    logic          r_start;
    logic          r_framing_err;
    logic          r_overrun_err;

    logic w_line;
    logic w_fall;
    logic w_accept;

    assign w_line   = r_sync2;
    // Requiring prev=1 means a line held low after a break cannot retrigger.
    assign w_fall   = r_prev & ~w_line;
    assign w_accept = r_rx_valid & i_rx_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_prev        <= 1'b1;
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_count   <= 4'd0;
            r_shift       <= 8'h00;
            r_rx          <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_start       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_sync1       <= i_data;
            r_sync2       <= r_sync1;
            r_prev        <= r_sync2;
            r_start       <= 1'b0;
            r_framing_err <= 1'b0;

            if (w_accept) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt       <= '0;
                    r_bit_count <= 4'd0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (i_baud) begin
                        if (r_cnt == HALF_LAST) begin
                            r_cnt <= '0;
                            if (!w_line) begin
                                r_start <= 1'b1;
                                r_state <= S_DATA;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (i_baud) begin
                        if (r_cnt == FULL_LAST) begin
                            r_cnt                      <= '0;
                            r_shift[r_bit_count[2:0]]  <= w_line;
                            r_bit_count                <= r_bit_count + 4'd1;
                            if (r_bit_count == 4'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                S_STOP: begin
                    if (i_baud) begin
                        if (r_cnt == FULL_LAST) begin
                            r_cnt       <= '0;
                            r_bit_count <= 4'd0;
                            r_state     <= S_IDLE;
                            if (w_line) begin
                                // A load outranks a same-cycle acceptance of the old byte.
                                r_rx       <= r_shift;
                                r_rx_valid <= 1'b1;
                                if (r_rx_valid && !i_rx_ready) begin
                                    r_overrun_err <= 1'b1;
                                end
                            end else begin
                                r_framing_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rx          = r_rx;
    assign o_rx_valid    = r_rx_valid;
    assign o_bit_count   = r_bit_count;
    assign o_start       = r_start;
    assign o_busy        = (r_state != S_IDLE);
    assign o_framing_err = r_framing_err;
    assign o_overrun_err = r_overrun_err;
    assign o_state       = r_state;

endmodule
